// File: rtl/rr_record_packer.sv
// Record-path compaction stage: squeezes valid logb channels toward the LSB behind the
// bitmaps and reports the unit bit length. Optional stats counters: RR_RECORD_PACKER_STATS_EN.
package rr_record_packer_pkg;
  // Sum of the first cnt fields (each fw bits wide) of a packed parameter vector.
  function automatic int sum_fields(input int cnt, input int fw, input logic [1023:0] v);
    int s;
    s = 0;
    for (int i = 0; i < cnt; i++) begin
      s += int'((v >> (i * fw)) & ((1024'(1) << fw) - 1024'(1)));
    end
    return s;
  endfunction
endpackage

module rr_record_packer #(
  parameter int LOGB_CHANNEL_CNT      = 4,
  parameter int LOGE_CHANNEL_CNT      = 4,
  parameter int RR_CHANNEL_WIDTH_BITS = 16,
  parameter logic [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS =
    {16'd8, 16'd16, 16'd32, 16'd64},
  localparam int SUM_W = rr_record_packer_pkg::sum_fields(LOGB_CHANNEL_CNT,
    RR_CHANNEL_WIDTH_BITS, 1024'(CHANNEL_WIDTHS)),
  localparam int FULL_WIDTH   = SUM_W + LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT,
  localparam int OFFSET_WIDTH = $clog2(FULL_WIDTH + 1)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LOGB_CHANNEL_CNT-1:0] in_logb_valid,
  input  logic [LOGE_CHANNEL_CNT-1:0] in_loge_valid,
  input  logic [SUM_W-1:0]            in_logb_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [FULL_WIDTH-1:0]       out_data,
  output logic [OFFSET_WIDTH-1:0]     out_len,
  output logic                        idle
`ifdef RR_RECORD_PACKER_STATS_EN
  ,
  output logic [63:0]                 stat_units,
  output logic [63:0]                 stat_bits,
  output logic [31:0]                 stat_drops
`endif
);

  localparam int BMAP_W = LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT;

  logic s1_valid, s2_valid;
  logic s1_load, s2_load, accept, unit_empty;

  logic [LOGB_CHANNEL_CNT-1:0]                   s1_logb;
  logic [LOGE_CHANNEL_CNT-1:0]                   s1_loge;
  logic [SUM_W-1:0]                              s1_data;
  logic [LOGB_CHANNEL_CNT-1:0][OFFSET_WIDTH-1:0] s1_off;
  logic [OFFSET_WIDTH-1:0]                       s1_len;

  logic [LOGB_CHANNEL_CNT-1:0][OFFSET_WIDTH-1:0] off_comb;
  logic [OFFSET_WIDTH-1:0]                       off_acc;
  logic [OFFSET_WIDTH-1:0]                       len_comb;

  logic [LOGB_CHANNEL_CNT-1:0][FULL_WIDTH-1:0]   chan_ext;
  logic [FULL_WIDTH-1:0]                         len_mask;
  logic [FULL_WIDTH-1:0]                         pack_comb;

  assign s2_load    = !s2_valid || out_ready;
  assign s1_load    = !s1_valid || s2_load;
  assign in_ready   = s1_load;
  assign accept     = in_valid && in_ready;
  assign unit_empty = !(|in_logb_valid) && !(|in_loge_valid);

  assign out_valid  = s2_valid;
  assign idle       = !s1_valid && !s2_valid;

  // Running offset: each valid channel lands right after the previous valid one.
  always_comb begin
    off_acc  = OFFSET_WIDTH'(BMAP_W);
    off_comb = '0;
    for (int i = 0; i < LOGB_CHANNEL_CNT; i++) begin
      off_comb[i] = off_acc;
      if (in_logb_valid[i]) begin
        off_acc = off_acc + OFFSET_WIDTH'(CHANNEL_WIDTHS[i]);
      end
    end
    len_comb = off_acc;
  end

  // Empty units are consumed here and never occupy S1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_logb  <= '0;
      s1_loge  <= '0;
      s1_data  <= '0;
      s1_off   <= '0;
      s1_len   <= '0;
    end else if (s1_load) begin
      s1_valid <= accept && !unit_empty;
      if (accept) begin
        s1_logb <= in_logb_valid;
        s1_loge <= in_loge_valid;
        s1_data <= in_logb_data;
        s1_off  <= off_comb;
        s1_len  <= len_comb;
      end
    end
  end

  for (genvar g = 0; g < LOGB_CHANNEL_CNT; g++) begin : g_chan
    localparam int W    = int'(CHANNEL_WIDTHS[g]);
    localparam int BASE = rr_record_packer_pkg::sum_fields(g, RR_CHANNEL_WIDTH_BITS,
                                                           1024'(CHANNEL_WIDTHS));
    assign chan_ext[g] = FULL_WIDTH'(s1_data[BASE +: W]);
  end

  // Shift by FULL_WIDTH yields zero, so a full-length unit keeps every bit.
  assign len_mask = ~({FULL_WIDTH{1'b1}} << s1_len);

  always_comb begin
    pack_comb = '0;
    pack_comb[LOGB_CHANNEL_CNT-1:0]      = s1_logb;
    pack_comb[BMAP_W-1:LOGB_CHANNEL_CNT] = s1_loge;
    for (int i = 0; i < LOGB_CHANNEL_CNT; i++) begin
      if (s1_logb[i]) begin
        pack_comb = pack_comb | (chan_ext[i] << s1_off[i]);
      end
    end
    pack_comb = pack_comb & len_mask;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      out_len  <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      out_data <= s1_valid ? pack_comb : '0;
      out_len  <= s1_valid ? s1_len : '0;
    end
  end

`ifdef RR_RECORD_PACKER_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_units <= '0;
      stat_bits  <= '0;
      stat_drops <= '0;
    end else begin
      if (out_valid && out_ready) begin
        stat_units <= stat_units + 64'd1;
        stat_bits  <= stat_bits + 64'(out_len);
      end
      if (accept && unit_empty) begin
        stat_drops <= stat_drops + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rr_record_packer.sv
// Scoreboard bench for rr_record_packer: a bit-serial packing model predicts each unit;
// the output monitor pops and compares. Stats ports follow RR_RECORD_PACKER_STATS_EN.
module tb_rr_record_packer;

  typedef struct {
    logic [127:0] data;
    logic [7:0]   len;
    int           acc_cyc;
  } sb_t;

  localparam int WS[4]    = '{64, 32, 16, 8};
  localparam int BASES[4] = '{0, 64, 96, 112};

  logic         clk = 1'b0;
  logic         rstn;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_logb_valid;
  logic [3:0]   in_loge_valid;
  logic [119:0] in_logb_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [7:0]   out_len;
  logic         idle;
`ifdef RR_RECORD_PACKER_STATS_EN
  logic [63:0]  stat_units;
  logic [63:0]  stat_bits;
  logic [31:0]  stat_drops;
`endif

  rr_record_packer dut (
    .clk           (clk),
    .rstn          (rstn),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_logb_valid (in_logb_valid),
    .in_loge_valid (in_loge_valid),
    .in_logb_data  (in_logb_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_len       (out_len),
    .idle          (idle)
`ifdef RR_RECORD_PACKER_STATS_EN
    ,
    .stat_units    (stat_units),
    .stat_bits     (stat_bits),
    .stat_drops    (stat_drops)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  sb_t sb[$];
  int pop_cyc_q[$];
  sb_t mon_e;
  logic lat_chk = 1'b0;
  int out_count = 0;
  int acc_count = 0;
  logic [127:0] last_data;
  logic [7:0]   last_len;
  logic [63:0]  exp_units = 0;
  logic [63:0]  exp_bits  = 0;
  logic [31:0]  exp_drops = 0;
  logic rnd_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic sb_t model(input logic [3:0] lb, input logic [3:0] le,
                                input logic [119:0] d, input int acc);
    sb_t r;
    int pos;
    r.data = '0;
    r.data[3:0] = lb;
    r.data[7:4] = le;
    pos = 8;
    for (int ch = 0; ch < 4; ch++) begin
      if (lb[ch]) begin
        for (int b = 0; b < WS[ch]; b++) r.data[pos + b] = d[BASES[ch] + b];
        pos += WS[ch];
      end
    end
    r.len = 8'(pos);
    r.acc_cyc = acc;
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the acceptance edge.
  task automatic send(input logic [3:0] lb, input logic [3:0] le, input logic [119:0] d);
    int t;
    logic acc;
    logic done;
    t = 0;
    done = 1'b0;
    in_valid = 1'b1;
    in_logb_valid = lb;
    in_loge_valid = le;
    in_logb_data = d;
    while (!done) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) begin
        if (lb != 4'd0 || le != 4'd0) sb.push_back(model(lb, le, d, cyc));
        else exp_drops++;
        acc_count++;
      end
      @(posedge clk);
      #1;
      if (acc) done = 1'b1;
      else begin
        t++;
        if (t >= 60) begin
          check_val("send_timeout", 128'(1), 128'(0));
          done = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
    in_logb_valid = '0;
    in_loge_valid = '0;
    in_logb_data = '0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    check_val("drain", 128'(sb.size()), 128'(0));
  endtask

  always @(negedge clk) begin
    if (rstn && out_valid) begin
      if (out_ready) begin
        if (sb.size() == 0) begin
          check_val("unexpected_out", 128'(1), 128'(0));
        end else begin
          mon_e = sb.pop_front();
          check_val("out_data", out_data, mon_e.data);
          check_val("out_len", 128'(out_len), 128'(mon_e.len));
          if (lat_chk) check_val("latency", 128'(cyc - mon_e.acc_cyc), 128'(2));
          exp_units = exp_units + 64'd1;
          exp_bits  = exp_bits + 64'(mon_e.len);
        end
        last_data = out_data;
        last_len  = out_len;
        out_count++;
        pop_cyc_q.push_back(cyc);
      end else if (sb.size() > 0) begin
        check_val("stall_data", out_data, sb[0].data);
        check_val("stall_len", 128'(out_len), 128'(sb[0].len));
      end
    end
  end

  function automatic logic [119:0] rnd_data();
    logic [119:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    return d;
  endfunction

  initial begin
    int c0;
    int n0;
    rstn = 1'b0;
    in_valid = 1'b0;
    in_logb_valid = '0;
    in_loge_valid = '0;
    in_logb_data = '0;
    out_ready = 1'b1;
    rnd_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_out_valid", 128'(out_valid), 128'(0));
    check_val("rst_idle", 128'(idle), 128'(1));
    check_val("rst_out_len", 128'(out_len), 128'(0));
    check_val("rst_out_data", out_data, 128'(0));
`ifdef RR_RECORD_PACKER_STATS_EN
    check_val("rst_stat_units", 128'(stat_units), 128'(0));
`endif
    rstn = 1'b1;
    #1;
    check_val("rst_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;

    // Non-adjacent logb channels; junk in the invalid channels must vanish.
    lat_chk = 1'b1;
    send(4'b0101, 4'h0, {8'hFF, 16'h1234, 32'hDEAD_BEEF, 64'hAAAA_BBBB_CCCC_DDDD});
    wait_drain();
    check_val("t1_data", last_data, {40'h0, 16'h1234, 64'hAAAA_BBBB_CCCC_DDDD, 8'h05});
    check_val("t1_len", 128'(last_len), 128'(88));

    send(4'b1000, 4'b0010, {8'h5A, 16'hFFFF, 32'h1111_2222, 64'h3});
    wait_drain();
    check_val("t2_data", last_data, 128'h5A28);
    check_val("t2_len", 128'(last_len), 128'(16));

    // Loge-only unit.
    send(4'b0000, 4'b1001, rnd_data());
    wait_drain();
    check_val("loge_only_len", 128'(last_len), 128'(8));
    lat_chk = 1'b0;

    // Empty unit between two valid ones.
    n0 = out_count;
    send(4'b0011, 4'b0001, rnd_data());
    send(4'b0000, 4'b0000, rnd_data());
    send(4'b0100, 4'b1100, rnd_data());
    wait_drain();
    check_val("t3_out_count", 128'(out_count - n0), 128'(2));
`ifdef RR_RECORD_PACKER_STATS_EN
    check_val("t3_stat_drops", 128'(stat_drops), 128'(exp_drops));
    check_val("t3_drops_one", 128'(stat_drops), 128'(1));
`endif

    // Backpressure for 10 cycles under continuous input.
    n0 = out_count;
    acc_count = 0;
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 6; k++) send(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)), rnd_data());
      end
      begin
        repeat (10) @(negedge clk);
        check_val("t4_held_units", 128'(acc_count), 128'(2));
        check_val("t4_in_ready_low", 128'(in_ready), 128'(0));
        check_val("t4_idle_low", 128'(idle), 128'(0));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check_val("t4_out_count", 128'(out_count - n0), 128'(6));

    // Random traffic with random backpressure, empties included.
    fork
      begin
        for (int k = 0; k < 24; k++) begin
          if (k % 7 == 3) send(4'h0, 4'h0, rnd_data());
          else send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), rnd_data());
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    wait_drain();
`ifdef RR_RECORD_PACKER_STATS_EN
    check_val("rnd_stat_units", 128'(stat_units), 128'(exp_units));
    check_val("rnd_stat_bits", 128'(stat_bits), 128'(exp_bits));
    check_val("rnd_stat_drops", 128'(stat_drops), 128'(exp_drops));
`endif

    // Reset while both stages hold units.
    out_ready = 1'b0;
    send(4'b0001, 4'b0000, rnd_data());
    send(4'b0010, 4'b0000, rnd_data());
    check_val("t5_full_out_valid", 128'(out_valid), 128'(1));
    check_val("t5_full_in_ready", 128'(in_ready), 128'(0));
    rstn = 1'b0;
    #1;
    check_val("t5_out_valid", 128'(out_valid), 128'(0));
    check_val("t5_idle", 128'(idle), 128'(1));
    sb.delete();
    exp_units = 0;
    exp_bits  = 0;
    exp_drops = 0;
    #2;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    lat_chk = 1'b1;
    send(4'b0110, 4'b0101, rnd_data());
    wait_drain();
    lat_chk = 1'b0;
`ifdef RR_RECORD_PACKER_STATS_EN
    check_val("t5_stat_units", 128'(stat_units), 128'(1));
`endif

    // Full utilisation, back-to-back.
    pop_cyc_q.delete();
    c0 = cyc;
    for (int k = 0; k < 4; k++) send(4'hF, 4'hF, rnd_data());
    check_val("t6_accept_rate", 128'(cyc - c0), 128'(4));
    wait_drain();
    check_val("t6_len", 128'(last_len), 128'(128));
    check_val("t6_out_count", 128'(pop_cyc_q.size()), 128'(4));
    if (pop_cyc_q.size() == 4)
      check_val("t6_out_rate", 128'(pop_cyc_q[3] - pop_cyc_q[0]), 128'(3));
    check_val("end_idle", 128'(idle), 128'(1));
`ifdef RR_RECORD_PACKER_STATS_EN
    check_val("end_stat_units", 128'(stat_units), 128'(exp_units));
    check_val("end_stat_bits", 128'(stat_bits), 128'(exp_bits));
    check_val("end_stat_drops", 128'(stat_drops), 128'(exp_drops));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_record_packer.md
Name: rr_record_packer

Overview:
- Record-path compaction stage. Sits directly upstream of the AXI storage backend's record port and drives its rr_stream_bus_t consumer interface (valid/ready/data/len).
- Accepts one logging unit per cycle in a fixed per-channel layout, plus logb/loge valid bitmaps.
- Squeezes the valid logb channels toward the LSB and computes the unit's bit length.
- Emits the packed unit in the backend's format, LSB to MSB: logb_valid, loge_valid, packed logb data.

Parameters:
- LOGB_CHANNEL_CNT, 4, number of logb channels.
- LOGE_CHANNEL_CNT, 4, number of loge channels.
- RR_CHANNEL_WIDTH_BITS, 16, bit width of each per-channel width field.
- CHANNEL_WIDTHS, {8,16,32,64} (index 0 = 64), packed array [LOGB_CHANNEL_CNT][RR_CHANNEL_WIDTH_BITS] giving the width of each logb channel, already in shuffled order.
- Derived localparam SUM_W: sum of CHANNEL_WIDTHS.
- Derived localparam FULL_WIDTH: SUM_W + LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT.
- Derived localparam OFFSET_WIDTH: $clog2(FULL_WIDTH+1).

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  input unit valid.
- in_ready  out  1  input unit accepted when in_valid && in_ready.
- in_logb_valid  in  LOGB_CHANNEL_CNT  logb channel valid bitmap.
- in_loge_valid  in  LOGE_CHANNEL_CNT  loge channel valid bitmap.
- in_logb_data  in  SUM_W  fixed layout; channel i at bit offset sum(CHANNEL_WIDTHS[0..i-1]).
- out_valid  out  1  packed unit valid.
- out_ready  in  1  downstream ready.
- out_data  out  FULL_WIDTH  packed unit; bits above out_len are zero.
- out_len  out  OFFSET_WIDTH  number of meaningful bits in out_data.
- idle  out  1  high when no unit is held in either pipeline stage.

Behaviour:
- Reset: asynchronous assert on rstn low. Stage valids clear, so out_valid=0, out_data=0, out_len=0, idle=1, stats counters=0. in_ready is 1 as soon as rstn is high.
- Reset mid-operation discards in-flight units; no partial output.
- Two-stage pipeline, S1 then S2. S2 drives the outputs directly from registers.
- Latency: 2 cycles from input acceptance to out_valid when there is no backpressure. Sustained throughput is 1 unit per cycle.
- Stage advance: S2 loads when !s2_valid || out_ready. S1 loads when !s1_valid || S1 moves into S2.
- in_ready = !s1_valid || s2_load. It depends combinationally on out_ready; there is no skid buffer.
- S1 captures the input and computes per-channel offsets.
  - off[0] = LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT.
  - off[i] = off[i-1] + (logb_valid[i-1] ? CHANNEL_WIDTHS[i-1] : 0).
  - len = off[LOGB_CHANNEL_CNT-1] + (logb_valid[last] ? CHANNEL_WIDTHS[last] : 0).
  - All arithmetic is unsigned OFFSET_WIDTH; it cannot overflow by construction.
- S2 computes out_data = {loge,logb bitmaps at LSB} OR over valid i of (zero-extended channel i data << off[i]).
  - Invalid channels contribute nothing.
  - out_data bits at or above len are forced to 0.
- Empty unit (logb_valid==0 and loge_valid==0): accepted (in_ready honoured) but dropped in S1. Never emitted, no bubble toward out_valid.
- Loge-only unit (logb 0, loge nonzero): emitted with len = LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT.
- out_valid, out_data and out_len are held stable while out_valid && !out_ready.
- Ordering is strictly preserved.
- idle = !s1_valid && !s2_valid.

Optional Feature:
- Macro RR_RECORD_PACKER_STATS_EN.
- Defined: adds outputs stat_units [63:0], stat_bits [63:0] and stat_drops [31:0].
  - stat_units increments on each out_valid && out_ready.
  - stat_bits adds out_len on each out_valid && out_ready.
  - stat_drops increments for each accepted empty unit.
  - All three wrap on overflow and reset to 0 asynchronously.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Test Plan:
- All tests use default parameters: FULL_WIDTH=128, OFFSET_WIDTH=8.
- Test 1, non-adjacent logb channels: logb=4'b0101, loge=0, ch0=64'hAAAA_BBBB_CCCC_DDDD, ch2=16'h1234, out_ready=1 -> 2 cycles later out_len=88, out_data[3:0]=4'b0101, [7:4]=0, [71:8]=ch0, [87:72]=16'h1234, [127:88]=0.
- Test 2, single logb plus loge: logb=4'b1000 with ch3=8'h5A, loge=4'b0010 -> out_len=16, out_data[15:0]=16'h5A28, rest 0.
- Test 3, empty unit between two valid ones: 3 back-to-back units, the middle one with both bitmaps 0 -> exactly 2 outputs in order; stat_drops=1 with the macro defined.
- Test 4, backpressure: continuous input with out_ready held low 10 cycles -> in_ready falls after 2 units are held; releasing out_ready yields all units in order, no loss or duplication, and outputs stay stable while stalled.
- Test 5, reset mid-stream: rstn pulsed low while both stages are full -> out_valid=0 and idle=1 immediately; the first post-reset unit appears 2 cycles after acceptance.
- Test 6, full utilisation: logb=4'hF, loge=4'hF -> out_len=128, every out_data bit is meaningful, and back-to-back units stream at 1 per cycle.
